// File: rtl/cr16_sequencer.sv
// CR16 fetch/decode/execute sequencer: drives the memory handshake, register-file and
// flag strobes, and the PC enable/select controls. Every output is a registered value.
module cr16_sequencer #(
  parameter int P_INSTR_WIDTH = 16,
  parameter int P_MEM_TIMEOUT = 255
) (
  input  logic                     I_CLK,
  input  logic                     I_RESET,
  input  logic                     I_HALT,
  input  logic [P_INSTR_WIDTH-1:0] I_MEM_RDATA,
  input  logic                     I_MEM_ACK,
  input  logic                     I_COND_TRUE,
  output logic                     O_MEM_REQ,
  output logic                     O_MEM_WE,
  output logic                     O_MEM_ADDR_SEL,
  output logic [P_INSTR_WIDTH-1:0] O_INSTR,
  output logic                     O_RF_WE,
  output logic [1:0]               O_RF_WDATA_SEL,
  output logic                     O_FLAGS_WE,
  output logic                     O_PC_ENABLE,
  output logic                     O_PC_ADDRESS_SELECT,
  output logic                     O_PC_ADDRESS_SELECT_INCREMENT,
  output logic                     O_PC_ADDRESS_SELECT_DISPLACE,
  output logic                     O_ERROR,
  output logic [2:0]               O_STATE
);

  localparam int CW = $clog2(P_MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(P_MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_PC_UPDATE = 3'd4,
    S_ERROR     = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_CMP, C_LOAD, C_STOR, C_JAL, C_JCOND, C_SCOND, C_BCOND
  } cls_t;

  function automatic cls_t decode(input logic [P_INSTR_WIDTH-1:0] ir);
    logic [3:0] op;
    logic [3:0] ext;
    cls_t       c;
    op  = ir[15:12];
    ext = ir[7:4];
    c   = C_ALU;
    if (ir == '0) c = C_NOP;
    else if (op == 4'h4) begin
      case (ext)
        4'h0:    c = C_LOAD;
        4'h4:    c = C_STOR;
        4'h8:    c = C_JAL;
        4'hC:    c = C_JCOND;
        4'hD:    c = C_SCOND;
        default: c = C_NOP;
      endcase
    end
    else if ((op == 4'h0 && ext == 4'hB) || op == 4'hB) c = C_CMP;
    else if (op == 4'hC) c = C_BCOND;
    return c;
  endfunction

  state_t                   state_q, state_d;
  cls_t                     cls_q, cls_d, dec;
  logic [P_INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                     req_q, req_d, we_q, we_d, asel_q, asel_d;
  logic                     rf_we_q, rf_we_d, flags_we_q, flags_we_d, pc_en_q, pc_en_d;
  logic [1:0]               wsel_q, wsel_d;
  logic                     sel_q, sel_d, inc_q, inc_d, disp_q, disp_d;
  logic                     err_q, err_d, timeout;
  logic [CW-1:0]            cnt_q, cnt_d;

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q    <= S_FETCH;
      cls_q      <= C_NOP;
      instr_q    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      asel_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      wsel_q     <= '0;
      flags_we_q <= 1'b0;
      pc_en_q    <= 1'b0;
      sel_q      <= 1'b0;
      inc_q      <= 1'b0;
      disp_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      instr_q    <= instr_d;
      req_q      <= req_d;
      we_q       <= we_d;
      asel_q     <= asel_d;
      rf_we_q    <= rf_we_d;
      wsel_q     <= wsel_d;
      flags_we_q <= flags_we_d;
      pc_en_q    <= pc_en_d;
      sel_q      <= sel_d;
      inc_q      <= inc_d;
      disp_q     <= disp_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    instr_d    = instr_q;
    req_d      = req_q;
    we_d       = we_q;
    asel_d     = asel_q;
    rf_we_d    = 1'b0;
    wsel_d     = '0;
    flags_we_d = 1'b0;
    pc_en_d    = 1'b0;
    sel_d      = sel_q;
    inc_d      = inc_q;
    disp_d     = disp_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    timeout    = 1'b0;
    dec        = decode(instr_q);

    // An ack in the limit cycle takes priority over the timeout.
    if (req_q) begin
      if (I_MEM_ACK)           cnt_d = '0;
      else if (cnt_q == LIMIT) timeout = 1'b1;
      else                     cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      S_FETCH: begin
        if (req_q) begin
          if (I_MEM_ACK) begin
            instr_d = I_MEM_RDATA;
            req_d   = 1'b0;
            state_d = S_DECODE;
          end
        end else if (!I_HALT) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          asel_d = 1'b0;
        end
      end
      S_DECODE: begin
        cls_d  = dec;
        sel_d  = 1'b0;
        inc_d  = 1'b0;
        disp_d = 1'b0;
        case (dec)
          C_JAL:   sel_d = 1'b1;
          C_JCOND: sel_d = I_COND_TRUE;
          C_BCOND: begin
            sel_d  = I_COND_TRUE;
            disp_d = I_COND_TRUE;
          end
          default: ;
        endcase
        if (dec == C_LOAD || dec == C_STOR) begin
          state_d = S_MEM;
          req_d   = 1'b1;
          we_d    = (dec == C_STOR);
          asel_d  = 1'b1;
        end else begin
          state_d = S_EXECUTE;
          case (dec)
            C_ALU: begin
              rf_we_d    = 1'b1;
              flags_we_d = 1'b1;
            end
            C_CMP:   flags_we_d = 1'b1;
            C_SCOND: begin
              rf_we_d = 1'b1;
              wsel_d  = 2'd3;
            end
            C_JAL: begin
              rf_we_d = 1'b1;
              wsel_d  = 2'd2;
            end
            default: ;
          endcase
        end
      end
      S_EXECUTE: begin
        state_d = S_PC_UPDATE;
        pc_en_d = 1'b1;
      end
      S_MEM: begin
        if (I_MEM_ACK) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          asel_d  = 1'b0;
          state_d = S_PC_UPDATE;
          pc_en_d = 1'b1;
          if (cls_q == C_LOAD) begin
            rf_we_d = 1'b1;
            wsel_d  = 2'd1;
          end
        end
      end
      S_PC_UPDATE: begin
        state_d = S_FETCH;
        sel_d   = 1'b0;
        inc_d   = 1'b0;
        disp_d  = 1'b0;
      end
      S_ERROR: begin
        req_d  = 1'b0;
        we_d   = 1'b0;
        asel_d = 1'b0;
        sel_d  = 1'b0;
        inc_d  = 1'b0;
        disp_d = 1'b0;
      end
      default: begin
        state_d = S_FETCH;
        req_d   = 1'b0;
      end
    endcase

    if (timeout) begin
      state_d    = S_ERROR;
      err_d      = 1'b1;
      req_d      = 1'b0;
      we_d       = 1'b0;
      asel_d     = 1'b0;
      rf_we_d    = 1'b0;
      wsel_d     = '0;
      flags_we_d = 1'b0;
      pc_en_d    = 1'b0;
      sel_d      = 1'b0;
      inc_d      = 1'b0;
      disp_d     = 1'b0;
    end
  end

  assign O_MEM_REQ                     = req_q;
  assign O_MEM_WE                      = we_q;
  assign O_MEM_ADDR_SEL                = asel_q;
  assign O_INSTR                       = instr_q;
  assign O_RF_WE                       = rf_we_q;
  assign O_RF_WDATA_SEL                = wsel_q;
  assign O_FLAGS_WE                    = flags_we_q;
  assign O_PC_ENABLE                   = pc_en_q;
  assign O_PC_ADDRESS_SELECT           = sel_q;
  assign O_PC_ADDRESS_SELECT_INCREMENT = inc_q;
  assign O_PC_ADDRESS_SELECT_DISPLACE  = disp_q;
  assign O_ERROR                       = err_q;
  assign O_STATE                       = state_q;

endmodule
